// File: rtl/ws2812_pkg.sv
// ws2812_pkg: constants shared by the WS2812 strip driver and receiver.
//   - Line timing in ns (T1H, T0H, bit period, reset gaps).
//   - GRB pixel width.
//   - Receiver state encoding.
package ws2812_pkg;
  localparam int T1H_NS          = 900;
  localparam int T0H_NS          = 350;
  localparam int T_BIT_NS        = 1250;
  localparam int T_RESET_NS      = 50000;
  localparam int T_RESET_LONG_NS = 280000;

  localparam int PIXEL_W = 24;

  typedef enum logic [1:0] {ST_SYNC, ST_IDLE, ST_HIGH, ST_LOW} ws_state_e;

  // Integer ceiling division for elaboration-time threshold math.
  function automatic int cdiv(input int n, input int d);
    return (n + d - 1) / d;
  endfunction
endpackage

// File: rtl/ws2812_rx_sync.sv
// ws2812_rx_sync: two-flop synchronizer for the asynchronous WS2812 line plus
// a previous-sample register for edge detection.
//   clk, reset_n : clock, synchronous active-low reset
//   data_in      : raw asynchronous line
//   level        : synchronized line (second stage)
//   rise, fall   : one-cycle edge indications derived from synchronized samples
module ws2812_rx_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic data_in,
  output logic level,
  output logic rise,
  output logic fall
);
  logic s1_q, s2_q, prev_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= data_in;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign level = s2_q;
  assign rise  = s2_q & ~prev_q;
  assign fall  = ~s2_q & prev_q;
endmodule

// File: rtl/ws2812_rx.sv
// ws2812_rx: WS2812 single-wire stream decoder. Classifies each high pulse by
// width, assembles 24-bit GRB pixels and presents them on the same
// rgb_data/led_num/write interface the strip driver consumes.
//   clk, reset_n : clock, synchronous active-low reset
//   data_in      : asynchronous WS2812 line
//   rgb_data     : last decoded pixel (bit 23 first on the wire)
//   led_num      : index of that pixel (first pixel of a frame = NUM_LEDS-1)
//   write        : one-cycle strobe, rgb_data/led_num valid
//   frame_done   : one-cycle strobe on a reset gap after >=1 received bit
//   error        : one-cycle strobe on a protocol violation
//   data_out     : forwarded stream
// Optional feature macro: WS2812_RX_PASSTHRU_EN. When defined, pixels beyond
// NUM_LEDS are forwarded on data_out instead of flagged; otherwise data_out=0.
module ws2812_rx
  import ws2812_pkg::*;
#(
  parameter int NUM_LEDS = 8,
  parameter int CLK_MHZ  = 12
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        data_in,
  output logic [23:0] rgb_data,
  output logic [7:0]  led_num,
  output logic        write,
  output logic        frame_done,
  output logic        error,
  output logic        data_out
);
  localparam int T_THRESH   = cdiv(CLK_MHZ * (T0H_NS + T1H_NS) / 2, 1000);
  localparam int T_MIN_RAW  = cdiv(CLK_MHZ * 150, 1000);
  localparam int T_MIN      = (T_MIN_RAW < 1) ? 1 : T_MIN_RAW;
  localparam int T_MAX_HIGH = CLK_MHZ * 5;
  localparam int T_RESET_RX = CLK_MHZ * T_RESET_NS / 1000;
  localparam int CW         = $clog2(T_RESET_RX + 1);

  localparam logic [CW-1:0] TH_C   = CW'(T_THRESH);
  localparam logic [CW-1:0] MIN_C  = CW'(T_MIN);
  localparam logic [CW-1:0] MAXH_C = CW'(T_MAX_HIGH);
  localparam logic [CW-1:0] RST_C  = CW'(T_RESET_RX);
  localparam logic [7:0]    LED_TOP = 8'(NUM_LEDS - 1);

  logic level, rise, fall;

  ws2812_rx_sync u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .data_in (data_in),
    .level   (level),
    .rise    (rise),
    .fall    (fall)
  );

  ws_state_e     state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_inc;
  logic [4:0]    bit_idx_q;
  logic [7:0]    led_idx_q;
  logic [22:0]   pix_q;      // first 23 bits of the pixel being assembled
  logic          full_q;     // NUM_LEDS pixels already written this frame
  logic          bit_val;
  logic [23:0]   pix_new;
`ifndef WS2812_RX_PASSTHRU_EN
  logic          ovf_err_q;  // overflow already reported this frame
`endif

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  assign bit_val = (cnt_q >= TH_C);
  assign pix_new = {pix_q, bit_val};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_SYNC;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      led_idx_q    <= '0;
      pix_q        <= '0;
      full_q       <= 1'b0;
      rgb_data     <= '0;
      led_num      <= '0;
      write        <= 1'b0;
      frame_done   <= 1'b0;
      error        <= 1'b0;
`ifndef WS2812_RX_PASSTHRU_EN
      ovf_err_q    <= 1'b0;
`endif
    end else begin
      write      <= 1'b0;
      frame_done <= 1'b0;
      error      <= 1'b0;
      case (state_q)
        ST_SYNC: begin
          full_q <= 1'b0;
          if (level)                cnt_q <= '0;
          else if (cnt_inc >= RST_C) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else                  cnt_q <= cnt_inc;
        end
        ST_IDLE: begin
          bit_idx_q <= 5'd23;
          led_idx_q <= LED_TOP;
          full_q    <= 1'b0;
`ifndef WS2812_RX_PASSTHRU_EN
          ovf_err_q <= 1'b0;
`endif
          if (rise) begin
            state_q <= ST_HIGH;
            cnt_q   <= CW'(1);
          end
        end
        ST_HIGH: begin
          if (fall) begin
            if (cnt_q < MIN_C) begin
              error   <= 1'b1;
              full_q  <= 1'b0;
              state_q <= ST_SYNC;
              cnt_q   <= '0;
            end else begin
              pix_q   <= pix_new[22:0];
              state_q <= ST_LOW;
              cnt_q   <= CW'(1);
              if (bit_idx_q == 5'd0) begin
                bit_idx_q <= 5'd23;
                if (!full_q) begin
                  write    <= 1'b1;
                  rgb_data <= pix_new;
                  led_num  <= led_idx_q;
                  if (led_idx_q == 8'd0) full_q    <= 1'b1;
                  else                   led_idx_q <= led_idx_q - 1'b1;
                end else begin
`ifdef WS2812_RX_PASSTHRU_EN
                  // overflow pixels leave via data_out, nothing to report
`else
                  if (!ovf_err_q) begin
                    error     <= 1'b1;
                    ovf_err_q <= 1'b1;
                  end
`endif
                end
              end else begin
                bit_idx_q <= bit_idx_q - 1'b1;
              end
            end
          end else if (cnt_inc >= MAXH_C) begin
            // line stuck high
            error   <= 1'b1;
            full_q  <= 1'b0;
            state_q <= ST_SYNC;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        ST_LOW: begin
          if (rise) begin
            state_q <= ST_HIGH;
            cnt_q   <= CW'(1);
          end else if (cnt_inc >= RST_C) begin
            frame_done <= 1'b1;
            if (bit_idx_q != 5'd23) error <= 1'b1;
            full_q  <= 1'b0;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        default: state_q <= ST_SYNC;
      endcase
    end
  end

`ifdef WS2812_RX_PASSTHRU_EN
  assign data_out = level & full_q & ((state_q == ST_HIGH) || (state_q == ST_LOW));
`else
  assign data_out = 1'b0;
`endif
endmodule

// File: tb/tb_ws2812_rx.sv
module tb_ws2812_rx;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        data_in;
  logic [23:0] rgb_data;
  logic [7:0]  led_num;
  logic        write, frame_done, error, data_out;

  ws2812_rx #(.NUM_LEDS(8), .CLK_MHZ(12)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .data_in    (data_in),
    .rgb_data   (rgb_data),
    .led_num    (led_num),
    .write      (write),
    .frame_done (frame_done),
    .error      (error),
    .data_out   (data_out)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int fd_cnt = 0;
  int err_cnt = 0;
  logic [31:0] sb[$];      // {led_num, rgb_data}
  logic chk_pass = 1'b0;   // compare data_out against delayed line
  logic d1 = 1'b0, d2 = 1'b0;

  // Monitor / scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    logic [31:0] exp;
    logic        exp_do;
    if (write) begin
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write got led_num=%0d rgb=%h, expected none", led_num, rgb_data);
      end else begin
        exp = sb.pop_front();
        if ({led_num, rgb_data} !== exp) begin
          n_fail++;
          $display("FAIL pixel got led_num=%0d rgb=%h, expected led_num=%0d rgb=%h",
                   led_num, rgb_data, exp[31:24], exp[23:0]);
        end
      end
      if (frame_done) begin
        n_chk++; n_fail++;
        $display("FAIL write_with_frame_done got both=1, expected exclusive");
      end
    end
    if (frame_done) fd_cnt++;
    if (error) err_cnt++;
    if (chk_pass) begin
`ifdef WS2812_RX_PASSTHRU_EN
      exp_do = d2;
`else
      exp_do = 1'b0;
`endif
      n_chk++;
      if (data_out !== exp_do) begin
        n_fail++;
        $display("FAIL data_out got %b, expected %b at %0t", data_out, exp_do, $time);
      end
    end
    d2 = d1;
    d1 = data_in;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_bit(input int hi, input int lo);
    data_in = 1'b1; cycles(hi);
    data_in = 1'b0; cycles(lo);
  endtask

  task automatic send_pix(input logic [23:0] p, input int h1, input int l1,
                          input int h0, input int l0);
    for (int i = 23; i >= 0; i--) begin
      if (p[i]) send_bit(h1, l1);
      else      send_bit(h0, l0);
    end
  endtask

  task automatic gap();
    data_in = 1'b0; cycles(700);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; data_in = 1'b0;
    cycles(5);
    n_chk++;
    if ({rgb_data, led_num, write, frame_done, error, data_out} !== 36'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got %h, expected 0",
               {rgb_data, led_num, write, frame_done, error, data_out});
    end
    reset_n = 1'b1;
    gap();
    n_chk++;
    if (fd_cnt !== 0 || err_cnt !== 0) begin
      n_fail++;
      $display("FAIL initial_sync got fd=%0d err=%0d, expected 0/0", fd_cnt, err_cnt);
    end
  endtask

  task automatic test_loopback();
    int fd0 = fd_cnt, e0 = err_cnt;
    for (int k = 0; k < 8; k++) sb.push_back({8'(7 - k), 24'h010100 + 24'(k)});
    for (int k = 0; k < 8; k++) send_pix(24'h010100 + 24'(k), 11, 4, 4, 11);
    gap();
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL loopback_writes got %0d pending, expected 0", sb.size());
    end
    n_chk++;
    if (fd_cnt - fd0 != 1 || err_cnt != e0) begin
      n_fail++;
      $display("FAIL loopback_flags got fd+%0d err+%0d, expected fd+1 err+0", fd_cnt - fd0, err_cnt - e0);
    end
  endtask

  task automatic test_widths();
    int fd0 = fd_cnt, e0 = err_cnt;
    sb.push_back({8'd7, 24'hFFFFFF}); send_pix(24'hFFFFFF, 10, 5, 10, 5);  gap();
    sb.push_back({8'd7, 24'h000000}); send_pix(24'h000000, 4, 11, 4, 11); gap();
    sb.push_back({8'd7, 24'hA5C33C}); send_pix(24'hA5C33C, 8, 7, 7, 8);   gap();
    // shortest accepted pulse decodes as 0
    sb.push_back({8'd7, 24'h00FF00}); send_pix(24'h00FF00, 9, 6, 2, 13);  gap();
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL widths_writes got %0d pending, expected 0", sb.size());
    end
    n_chk++;
    if (fd_cnt - fd0 != 4 || err_cnt != e0) begin
      n_fail++;
      $display("FAIL widths_flags got fd+%0d err+%0d, expected fd+4 err+0", fd_cnt - fd0, err_cnt - e0);
    end
  endtask

  task automatic test_glitch();
    int fd0 = fd_cnt, e0 = err_cnt;
    for (int i = 0; i < 5; i++) send_bit(10, 5);
    send_bit(1, 5);
    send_pix(24'h654321, 10, 5, 4, 11);   // ignored while resynchronizing
    gap();
    n_chk++;
    if (err_cnt - e0 != 1 || fd_cnt != fd0) begin
      n_fail++;
      $display("FAIL glitch_flags got err+%0d fd+%0d, expected err+1 fd+0", err_cnt - e0, fd_cnt - fd0);
    end
    sb.push_back({8'd7, 24'h123456}); send_pix(24'h123456, 10, 5, 4, 11); gap();
    n_chk++;
    if (sb.size() != 0 || fd_cnt - fd0 != 1) begin
      n_fail++;
      $display("FAIL glitch_recover got pending=%0d fd+%0d, expected 0 and fd+1", sb.size(), fd_cnt - fd0);
    end
  endtask

  task automatic test_stuck();
    int fd0 = fd_cnt, e0 = err_cnt;
    data_in = 1'b1; cycles(70);
    gap();
    n_chk++;
    if (err_cnt - e0 != 1 || fd_cnt != fd0) begin
      n_fail++;
      $display("FAIL stuck_high got err+%0d fd+%0d, expected err+1 fd+0", err_cnt - e0, fd_cnt - fd0);
    end
    for (int i = 0; i < 12; i++) send_bit(10, 5);
    gap();
    n_chk++;
    if (err_cnt - e0 != 2 || fd_cnt - fd0 != 1) begin
      n_fail++;
      $display("FAIL partial_frame got err+%0d fd+%0d, expected err+2 fd+1", err_cnt - e0, fd_cnt - fd0);
    end
  endtask

  task automatic test_overflow();
    int fd0 = fd_cnt, e0 = err_cnt;
    int exp_err;
`ifdef WS2812_RX_PASSTHRU_EN
    exp_err = 0;
`else
    exp_err = 1;
`endif
    for (int k = 0; k < 8; k++) sb.push_back({8'(7 - k), 24'hC00000 + 24'(k * 3)});
    for (int k = 0; k < 8; k++) send_pix(24'hC00000 + 24'(k * 3), 10, 5, 4, 11);
    chk_pass = 1'b1;
    send_pix(24'h5A5A5A, 10, 5, 4, 11);
    cycles(10);
    chk_pass = 1'b0;
    gap();
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL overflow_writes got %0d pending, expected 0", sb.size());
    end
    n_chk++;
    if (err_cnt - e0 != exp_err || fd_cnt - fd0 != 1) begin
      n_fail++;
      $display("FAIL overflow_flags got err+%0d fd+%0d, expected err+%0d fd+1",
               err_cnt - e0, fd_cnt - fd0, exp_err);
    end
  endtask

  task automatic test_reset_mid();
    int fd0 = fd_cnt, e0 = err_cnt;
    for (int i = 0; i < 10; i++) send_bit(10, 5);
    data_in = 1'b1; cycles(3);
    reset_n = 1'b0; data_in = 1'b0;
    cycles(1);
    reset_n = 1'b1;
    n_chk++;
    if ({rgb_data, led_num, write, frame_done, error, data_out} !== 36'd0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs got %h, expected 0",
               {rgb_data, led_num, write, frame_done, error, data_out});
    end
    cycles(20);
    send_pix(24'h0F0F0F, 10, 5, 4, 11);   // no gap yet: must be ignored
    gap();
    sb.push_back({8'd7, 24'hABCDEF}); send_pix(24'hABCDEF, 10, 5, 4, 11); gap();
    n_chk++;
    if (sb.size() != 0 || fd_cnt - fd0 != 1 || err_cnt != e0) begin
      n_fail++;
      $display("FAIL mid_reset_recover got pending=%0d fd+%0d err+%0d, expected 0/1/0",
               sb.size(), fd_cnt - fd0, err_cnt - e0);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    data_in = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_loopback();
    test_widths();
    test_glitch();
    test_stuck();
    test_overflow();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ws2812_rx.md
Name: ws2812_rx

Overview:
- Single-wire WS2812 stream decoder: samples a serial line, classifies each high pulse as 0/1 by width and assembles 24-bit GRB pixels.
- Outputs each pixel on an rgb_data/led_num/write interface identical to the strip driver's input, so a receiver can feed a driver directly.
- Used for loopback self-test of the strip driver and for acting as a daisy-chained pixel node.

Parameters:
- NUM_LEDS, 8, pixels accepted per frame; max 256.
- CLK_MHZ, 12, clock frequency in MHz; all thresholds derive from it.
- T_THRESH, ceil(CLK_MHZ*625/1000) = 8, high width in cycles at or above which a bit is 1.
- T_MIN, max(1, ceil(CLK_MHZ*150/1000)) = 2, high widths below this are glitches.
- T_MAX_HIGH, CLK_MHZ*5 = 60, high widths at or above this are stuck-line errors.
- T_RESET_RX, CLK_MHZ*50 = 600, low time that marks end of frame.
- Counter width: $clog2(T_RESET_RX+1). Counters saturate and never wrap.

Ports:
- clk, in, 1, system clock.
- reset_n, in, 1, reset, synchronous and active-low.
- data_in, in, 1, asynchronous WS2812 line.
- rgb_data, out, 24, last decoded pixel, bit 23 first on the wire.
- led_num, out, 8, index of that pixel.
- write, out, 1, one-cycle strobe when rgb_data/led_num are valid.
- frame_done, out, 1, one-cycle strobe on reset gap after ≥1 received bit.
- error, out, 1, one-cycle strobe on any protocol violation.
- data_out, out, 1, forwarded stream (see Optional Feature).

Behaviour:
- Reset (reset_n=0 at posedge): all outputs 0, counters 0, state SYNC. A reset mid-frame discards the partial pixel.
- Input path:
  - 2-flop synchronizer plus a previous-sample register.
  - Rise/fall edges are detected on synchronized samples.
- State SYNC: count consecutive low cycles. At T_RESET_RX, go to IDLE without a frame_done. Any high restarts the count.
- State IDLE: wait for a rise, then go to HIGH with the width counter at 1. bit_idx=23, led_idx=NUM_LEDS-1.
- State HIGH: count high cycles. On fall, classify width w:
  - w<T_MIN: error, drop partial pixel, go to SYNC.
  - otherwise the bit is (w≥T_THRESH), shifted into the pixel register; go to LOW.
  - If w reaches T_MAX_HIGH before any fall: error, go to SYNC.
- State LOW: count low cycles.
  - On rise: go to HIGH.
  - At T_RESET_RX: frame_done.
    - If bit_idx≠23 (partial pixel), also error.
    - Then go to IDLE with indices reset.
- Pixel complete (24th bit classified):
  - rgb_data/led_num are registered and write=1 for exactly one cycle.
  - Latency: 3 clk edges after the first edge that samples data_in low.
  - led_num = led_idx.
- Pixel order: the first pixel of a frame gets led_num=NUM_LEDS-1, then decrements, matching the driver's transmit order.
- Overflow: pixels beyond NUM_LEDS in one frame produce no write; error strobes once per frame. Without the feature, the stream is ignored until the reset gap.
- write and frame_done never assert in the same cycle. error may coincide with frame_done.
- rgb_data/led_num hold their value between writes.

Optional Feature:
- Macro: WS2812_RX_PASSTHRU_EN.
- Defined:
  - data_out = the second synchronizer stage, gated to 0 until NUM_LEDS pixels have completed this frame, then following the line until the next reset gap.
  - Overflow pixels are forwarded, not flagged as error.
  - data_out is 0 in SYNC, IDLE and after reset.
- Undefined: data_out is constant 0 and overflow flags error as above.

Decomposition:
- Shared package ws2812_pkg:
  - timing helper constants in ns: T1H 900, T0H 350, period 1250, reset gap 50000/280000;
  - the GRB 24-bit pixel width;
  - state encodings SYNC/IDLE/HIGH/LOW.
  The strip driver then uses the same constants.
- One natural sub-module: ws2812_rx_sync, the 2-flop synchronizer with edge detector, outputting level, rise and fall.

Test Plan:
- Loopback: driver (CLK_MHZ=12, NUM_LEDS=8) loaded with pixel k = 24'h0101_00 + k feeds data_in. After the initial reset gap, 8 writes occur with led_num 7..0 and matching rgb_data, then one frame_done and no error.
- Widths: after sync, send high 10/low 5 ×24. Expect one write with rgb 24'hFFFFFF. High 4/low 11 ×24 gives 24'h000000. High 7 decodes as 0 and high 8 as 1 (threshold edge).
- Glitch: a 1-cycle high mid-pixel gives error, no write, state SYNC. The next valid pixel is ignored until 600 low cycles elapse.
- Stuck high for 60 cycles gives error. Low 600 after 12 bits gives frame_done and error, no write.
- Overflow: a 9-pixel frame gives 8 writes and one error. With WS2812_RX_PASSTHRU_EN, no error and data_out reproduces pixel 9's waveform delayed 2 cycles.
- Assert reset_n=0 mid-pixel for 1 cycle: outputs all 0 next cycle. The next frame's first write has led_num=7 only after a full 600-cycle gap.
